// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the latch bank write sequencer.
// The optional readback stage is enabled with the LATCH_READBACK_EN macro.
package latch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        CHECK,
        DONE
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/latch_bank_write_sequencer_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter
    import latch_seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] j;

    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            j = sum[IW-1:0];
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_sequencer.sv
// Arbitrates NREQ writers onto one latch bank, sequencing setup / enable / hold.
// Define LATCH_READBACK_EN to add a one-cycle readback CHECK state before DONE.
module latch_bank_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int AW      = 3,
    parameter int SETUP_C = 1,
    parameter int EN_C    = 2,
    parameter int HOLD_C  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*AW-1:0]     addr_i,
    input  logic [NREQ*WIDTH-1:0]  wdata_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        ack_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic [WIDTH-1:0]       lat_d_o,
    output logic [DEPTH-1:0]       lat_en_o,
    input  logic [DEPTH*WIDTH-1:0] lat_q_i
);

    localparam int IW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             err_q, err_d;
    logic             flag_q, flag_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             addr_oor;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign addr_oor = 32'(addr_q) >= 32'(DEPTH);

`ifdef LATCH_READBACK_EN
    logic [WIDTH-1:0] rb_word;

    always_comb begin
        rb_word = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (32'(addr_q) == 32'(e)) begin
                rb_word = lat_q_i[e*WIDTH +: WIDTH];
            end
        end
    end
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q_i;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        lat_d_d  = lat_d_q;
        lat_en_d = lat_en_q;
        flag_d   = flag_q;
        gnt_d    = '0;
        ack_d    = '0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    addr_d  = addr_i[arb_idx*AW +: AW];
                    lat_d_d = wdata_i[arb_idx*WIDTH +: WIDTH];
                    flag_d  = 1'b0;
                    cnt_d   = CNT_W'(SETUP_C - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    // An out-of-range entry is never enabled; the write still runs its full timing.
                    lat_en_d = addr_oor ? '0 : ({{(DEPTH-1){1'b0}}, 1'b1} << addr_q);
                    flag_d   = addr_oor;
                    cnt_d    = CNT_W'(EN_C - 1);
                    state_d  = ENABLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ENABLE: begin
                if (cnt_q == '0) begin
                    lat_en_d = '0;
                    cnt_d    = CNT_W'(HOLD_C - 1);
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
`ifdef LATCH_READBACK_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef LATCH_READBACK_EN
            CHECK: begin
                if (!flag_q && (rb_word != lat_d_q)) begin
                    flag_d = 1'b1;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
                err_d   = flag_q;
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            flag_q   <= flag_d;
        end
    end

    // NOTE: capture registers are always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        addr_q <= addr_d;
    end

    assign gnt_o    = gnt_q;
    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != IDLE);
    assign lat_d_o  = lat_d_q;
    assign lat_en_o = lat_en_q;

endmodule

// File: tb/tb_latch_bank_write_sequencer.sv
// Directed self-checking bench for latch_bank_write_sequencer (AW widened to 4 so
// an out-of-range address can be presented). Honors LATCH_READBACK_EN if defined.
module tb_latch_bank_write_sequencer;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 4;
`ifdef LATCH_READBACK_EN
    localparam int LAT     = 6;
    localparam bit RB_ERR  = 1'b1;
`else
    localparam int LAT     = 5;
    localparam bit RB_ERR  = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_i;
    logic [NREQ*AW-1:0]     addr_i;
    logic [NREQ*WIDTH-1:0]  wdata_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        ack_o;
    logic                   err_o;
    logic                   busy_o;
    logic [WIDTH-1:0]       lat_d_o;
    logic [DEPTH-1:0]       lat_en_o;
    logic [DEPTH*WIDTH-1:0] lat_q_i;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             corrupt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    latch_bank_write_sequencer #(
        .NREQ  (NREQ),
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .busy_o   (busy_o),
        .lat_d_o  (lat_d_o),
        .lat_en_o (lat_en_o),
        .lat_q_i  (lat_q_i)
    );

    // Latch bank model; corrupt flips bit 0 of every read value.
    always @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (lat_en_o[e]) mem[e] <= lat_d_o;
        end
    end

    always_comb begin
        lat_q_i = '0;
        for (int e = 0; e < DEPTH; e++) begin
            lat_q_i[e*WIDTH +: WIDTH] = mem[e] ^ (corrupt ? 8'h01 : 8'h00);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt_o == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_ack(output int cyc, output logic [DEPTH-1:0] en_or);
        cyc   = 0;
        en_or = '0;
        do begin
            tick();
            cyc++;
            en_or |= lat_en_o;
        end while (ack_o == '0 && cyc < 20);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req_i   = '0;
        addr_i  = '0;
        wdata_i = '0;
        corrupt = 1'b0;
        tick();
        tick();
        checks++;
        if ({gnt_o, ack_o, err_o, busy_o, lat_en_o, lat_d_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b err=%b busy=%b en=%h d=%h, expected all zero",
                     gnt_o, ack_o, err_o, busy_o, lat_en_o, lat_d_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        logic [DEPTH-1:0] exp_en;
        logic [NREQ-1:0]  exp_ack;
        addr_i[0*AW +: AW]       = 4'd5;
        wdata_i[0*WIDTH +: WIDTH] = 8'hA5;
        req_i = 4'b0001;
        tick();
        checks++;
        if (gnt_o !== 4'b0001 || lat_d_o !== 8'hA5 || busy_o !== 1'b1 || lat_en_o !== '0) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b d=%h busy=%b en=%h, expected 0001 a5 1 00",
                     gnt_o, lat_d_o, busy_o, lat_en_o);
        end
        req_i = '0;
        for (int c = 1; c <= LAT; c++) begin
            tick();
            exp_en  = (c == 1 || c == 2) ? 8'h20 : 8'h00;
            exp_ack = (c == LAT) ? 4'b0001 : 4'b0000;
            checks++;
            if (lat_en_o !== exp_en || ack_o !== exp_ack || err_o !== 1'b0 || lat_d_o !== 8'hA5) begin
                failures++;
                $display("FAIL single_cycle%0d: got en=%h ack=%b err=%b d=%h, expected en=%h ack=%b err=0 d=a5",
                         c, lat_en_o, ack_o, err_o, lat_d_o, exp_en, exp_ack);
            end
        end
    endtask

    task automatic test_round_robin();
        int               cyc;
        logic [DEPTH-1:0] en_or;
        logic [NREQ-1:0]  exp_g;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            addr_i[i*AW +: AW]       = AW'(i + 1);
            wdata_i[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
        end
        req_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % NREQ);
            wait_gnt(cyc);
            checks++;
            if (gnt_o !== exp_g || lat_d_o !== WIDTH'(8'h10 + (n % NREQ)) || (n > 0 && cyc != 1)) begin
                failures++;
                $display("FAIL rr_grant%0d: got gnt=%b d=%h gap=%0d, expected gnt=%b d=%h gap=1",
                         n, gnt_o, lat_d_o, cyc, exp_g, 8'h10 + (n % NREQ));
            end
            if (n == 4) req_i = '0;
            wait_ack(cyc, en_or);
            checks++;
            if (ack_o !== exp_g || cyc != LAT || en_or !== (8'h01 << ((n % NREQ) + 1))) begin
                failures++;
                $display("FAIL rr_ack%0d: got ack=%b lat=%0d en=%h, expected ack=%b lat=%0d en=%h",
                         n, ack_o, cyc, en_or, exp_g, LAT, 8'h01 << ((n % NREQ) + 1));
            end
        end
    endtask

    task automatic test_out_of_range();
        int               cyc;
        logic [DEPTH-1:0] en_or;
        addr_i[2*AW +: AW]       = 4'd9;
        wdata_i[2*WIDTH +: WIDTH] = 8'h77;
        req_i = 4'b0100;
        wait_gnt(cyc);
        checks++;
        if (gnt_o !== 4'b0100) begin
            failures++;
            $display("FAIL oor_grant: got %b expected 0100", gnt_o);
        end
        req_i = '0;
        wait_ack(cyc, en_or);
        checks++;
        if (ack_o !== 4'b0100 || err_o !== 1'b1 || en_or !== '0 || cyc != LAT) begin
            failures++;
            $display("FAIL oor_ack: got ack=%b err=%b en=%h lat=%0d, expected 0100 1 00 %0d",
                     ack_o, err_o, en_or, cyc, LAT);
        end
        tick();
        checks++;
        if (err_o !== 1'b0 || ack_o !== '0) begin
            failures++;
            $display("FAIL oor_pulse: got err=%b ack=%b, expected 0 0000", err_o, ack_o);
        end
    endtask

    task automatic test_reset_abort();
        int               cyc;
        logic [DEPTH-1:0] en_or;
        logic [NREQ-1:0]  ack_or;
        addr_i[1*AW +: AW]       = 4'd2;
        wdata_i[1*WIDTH +: WIDTH] = 8'h3C;
        req_i = 4'b0010;
        wait_gnt(cyc);
        req_i = '0;
        cyc = 0;
        while (lat_en_o == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (lat_en_o !== 8'h04) begin
            failures++;
            $display("FAIL abort_enable: got en=%h expected 04", lat_en_o);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (lat_en_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: got en=%h busy=%b, expected 00 0", lat_en_o, busy_o);
        end
        rst_n  = 1'b1;
        ack_or = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            ack_or |= ack_o;
        end
        checks++;
        if (ack_or !== '0) begin
            failures++;
            $display("FAIL abort_no_ack: got ack=%b expected 0000", ack_or);
        end
        req_i = 4'b1010;
        wait_gnt(cyc);
        checks++;
        if (gnt_o !== 4'b0010) begin
            failures++;
            $display("FAIL abort_ptr: got gnt=%b expected 0010", gnt_o);
        end
        req_i = '0;
        wait_ack(cyc, en_or);
        checks++;
        if (ack_o !== 4'b0010 || mem[2] !== 8'h3C) begin
            failures++;
            $display("FAIL abort_rewrite: got ack=%b mem2=%h, expected 0010 3c", ack_o, mem[2]);
        end
    endtask

    task automatic test_drop_req();
        int               cyc;
        logic [DEPTH-1:0] en_or;
        addr_i[1*AW +: AW]       = 4'd4;
        wdata_i[1*WIDTH +: WIDTH] = 8'h5A;
        req_i = 4'b0010;
        wait_gnt(cyc);
        checks++;
        if (gnt_o !== 4'b0010) begin
            failures++;
            $display("FAIL drop_grant: got %b expected 0010", gnt_o);
        end
        req_i = '0;
        wait_ack(cyc, en_or);
        checks++;
        if (ack_o !== 4'b0010 || cyc != LAT || err_o !== 1'b0 || mem[4] !== 8'h5A || en_or !== 8'h10) begin
            failures++;
            $display("FAIL drop_ack: got ack=%b lat=%0d err=%b mem4=%h en=%h, expected 0010 %0d 0 5a 10",
                     ack_o, cyc, err_o, mem[4], en_or, LAT);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || gnt_o !== '0 || lat_d_o !== 8'h5A) begin
            failures++;
            $display("FAIL drop_idle: got busy=%b gnt=%b d=%h, expected 0 0000 5a", busy_o, gnt_o, lat_d_o);
        end
    endtask

    task automatic test_readback();
        int               cyc;
        logic [DEPTH-1:0] en_or;
        for (int pass = 0; pass < 2; pass++) begin
            corrupt = (pass == 0);
            addr_i[0*AW +: AW]       = (pass == 0) ? 4'd6 : 4'd7;
            wdata_i[0*WIDTH +: WIDTH] = (pass == 0) ? 8'hC3 : 8'h3C;
            req_i = 4'b0001;
            wait_gnt(cyc);
            checks++;
            if (gnt_o !== 4'b0001) begin
                failures++;
                $display("FAIL rb_grant%0d: got %b expected 0001", pass, gnt_o);
            end
            req_i = '0;
            wait_ack(cyc, en_or);
            checks++;
            if (ack_o !== 4'b0001 || cyc != LAT || err_o !== (pass == 0 ? RB_ERR : 1'b0)) begin
                failures++;
                $display("FAIL rb_ack%0d: got ack=%b lat=%0d err=%b, expected 0001 %0d %b",
                         pass, ack_o, cyc, err_o, LAT, (pass == 0 ? RB_ERR : 1'b0));
            end
        end
        corrupt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_out_of_range();
        test_reset_abort();
        test_drop_req();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
